// File: rtl/bin_search_engine.sv
// Sequential binary-search engine over a register-file array of sorted unsigned values.
// Supports exact-match and lower-bound searches on a start/busy/done handshake.
module bin_search_engine #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [IDX_W-1:0]  index
);

    // One extra bit on the bounds so hi can drop below lo without wrapping into range.
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FIN    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] key_q, key_d;
    logic              mode_q, mode_d;
    logic [PTR_W-1:0]  lo_q, lo_d;
    logic [PTR_W-1:0]  hi_q, hi_d;
    logic              cand_vld_q, cand_vld_d;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  mid;
    logic [IDX_W-1:0]  mid_idx;
    logic [DATA_W-1:0] mid_val;
    logic              go_low;
    logic              exit_now;

    assign sum     = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid     = PTR_W'(sum >> 1);
    assign mid_idx = mid[IDX_W-1:0];
    assign mid_val = mem_q[mid_idx];

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        mem_d      = mem_q;
        key_d      = key_q;
        mode_d     = mode_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        cand_vld_d = cand_vld_q;
        cand_d     = cand_q;
        found_d    = found_q;
        index_d    = index_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        go_low     = 1'b0;
        exit_now   = 1'b0;

        if (wr_en && !busy_q) begin
            mem_d[wr_addr] = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEARCH;
                    busy_d     = 1'b1;
                    key_d      = key;
                    mode_d     = mode;
                    lo_d       = '0;
                    hi_d       = PTR_TOP;
                    cand_vld_d = 1'b0;
                    cand_d     = '0;
                    found_d    = 1'b0;
                    index_d    = '0;
                end
            end
            SEARCH: begin
                // NOTE: always_comb uses blocking assignments so later statements see the values computed above them.
                go_low = mode_q ? (mid_val >= key_q) : (mid_val > key_q);
                if (!mode_q && (mid_val == key_q)) begin
                    found_d  = 1'b1;
                    index_d  = mid_idx;
                    exit_now = 1'b1;
                end else if (go_low) begin
                    hi_d     = mid - PTR_ONE;
                    exit_now = (mid == lo_q);
                    if (mode_q) begin
                        cand_vld_d = 1'b1;
                        cand_d     = mid_idx;
                    end
                end else begin
                    lo_d     = mid + PTR_ONE;
                    exit_now = ((mid + PTR_ONE) > hi_q);
                end

                if (exit_now) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (mode_q) begin
                        found_d = cand_vld_d;
                        index_d = cand_vld_d ? cand_d : '0;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            // NOTE: the array is built from flops, so reset clears it; a RAM macro could not be cleared this way.
            mem_q      <= '{default: '0};
            key_q      <= '0;
            mode_q     <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            cand_vld_q <= 1'b0;
            cand_q     <= '0;
            found_q    <= 1'b0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            cand_vld_q <= cand_vld_d;
            cand_q     <= cand_d;
            found_q    <= found_d;
            index_q    <= index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign index = index_q;

endmodule

// File: tb/tb_bin_search_engine.sv
// Bench for bin_search_engine: directed table vectors on a 16x8 instance,
// handshake corner cases, and a randomized 64x12 sweep against a linear-scan model.
module tb_bin_search_engine;

    logic clk;
    logic rst;

    // 16-entry, 8-bit instance
    logic       a_wr_en, a_start, a_mode, a_busy, a_done, a_found;
    logic [3:0] a_wr_addr, a_index;
    logic [7:0] a_wr_data, a_key;

    // 64-entry, 12-bit instance
    logic        b_wr_en, b_start, b_mode, b_busy, b_done, b_found;
    logic [5:0]  b_wr_addr, b_index;
    logic [11:0] b_wr_data, b_key;

    int n_cmp  = 0;
    int n_fail = 0;

    bin_search_engine #(.DATA_W(8), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .start(a_start), .key(a_key), .mode(a_mode),
        .busy(a_busy), .done(a_done), .found(a_found), .index(a_index)
    );

    bin_search_engine #(.DATA_W(12), .DEPTH(64)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .key(b_key), .mode(b_mode),
        .busy(b_busy), .done(b_done), .found(b_found), .index(b_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic       mode;
        logic       exp_found;
        logic [3:0] exp_index;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [7:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
    endtask

    task automatic a_load_tens();
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'(10 * i));
    endtask

    // lat = edges after the start edge until done is seen
    task automatic a_search(input logic [7:0] k, input logic m,
                            output logic f, output logic [3:0] idx, output int lat);
        a_key = k; a_mode = m; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        lat = 0;
        while (!a_done && lat < 40) begin
            tick();
            lat++;
        end
        f = a_found;
        idx = a_index;
    endtask

    task automatic b_write(input logic [5:0] addr, input logic [11:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
        tick();
        b_wr_en = 1'b0;
    endtask

    task automatic b_search(input logic [11:0] k, input logic m,
                            output logic f, output logic [5:0] idx, output int lat);
        b_key = k; b_mode = m; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 40) begin
            tick();
            lat++;
        end
        f = b_found;
        idx = b_index;
    endtask

    initial begin
        logic       f;
        logic [3:0] idx;
        int         lat;
        int         done_cnt;
        int         arr [64];

        a_wr_en = 0; a_start = 0; a_mode = 0; a_wr_addr = '0; a_wr_data = '0; a_key = '0;
        b_wr_en = 0; b_start = 0; b_mode = 0; b_wr_addr = '0; b_wr_data = '0; b_key = '0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("rst busy",  a_busy,  0);
        check("rst done",  a_done,  0);
        check("rst found", a_found, 0);
        check("rst index", a_index, 0);
        check("rst b busy", b_busy, 0);
        a_search(8'd1, 1'b1, f, idx, lat);
        check("rst array lb found", f, 0);
        tick();

        // Table-driven vectors on mem[i] = 10*i
        a_load_tens();
        vecs.push_back('{8'd70,  1'b0, 1'b1, 4'd7});
        vecs.push_back('{8'd75,  1'b0, 1'b0, 4'd0});
        vecs.push_back('{8'd75,  1'b1, 1'b1, 4'd8});
        vecs.push_back('{8'd0,   1'b0, 1'b1, 4'd0});
        vecs.push_back('{8'd150, 1'b0, 1'b1, 4'd15});
        vecs.push_back('{8'd200, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{8'd0,   1'b1, 1'b1, 4'd0});
        vecs.push_back('{8'd200, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{8'd5,   1'b1, 1'b1, 4'd1});
        vecs.push_back('{8'd151, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{8'd150, 1'b1, 1'b1, 4'd15});
        vecs.push_back('{8'd149, 1'b0, 1'b0, 4'd0});
        for (int i = 0; i < vecs.size(); i++) begin
            a_search(vecs[i].key, vecs[i].mode, f, idx, lat);
            check($sformatf("v%0d found", i), f, vecs[i].exp_found);
            check($sformatf("v%0d index", i), idx, vecs[i].exp_index);
            check($sformatf("v%0d latency<=6", i), (lat <= 6), 1);
            tick();
            check($sformatf("v%0d done pulse width", i), a_done, 0);
        end

        // Write and start in the same idle cycle: search sees the new value
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 8'd75;
        a_key = 8'd75; a_mode = 1'b0; a_start = 1'b1;
        tick();
        a_wr_en = 1'b0; a_start = 1'b0;
        lat = 0;
        while (!a_done && lat < 40) begin tick(); lat++; end
        check("wr+start found", a_found, 1);
        check("wr+start index", a_index, 7);
        tick();
        a_write(4'd7, 8'd70);

        // Duplicates
        for (int i = 0; i < 16; i++) a_write(4'(i), (i < 4) ? 8'd5 : 8'(5 + i));
        a_search(8'd5, 1'b1, f, idx, lat);
        check("dup lb found", f, 1);
        check("dup lb index", idx, 0);
        tick();
        a_search(8'd5, 1'b0, f, idx, lat);
        check("dup exact found", f, 1);
        check("dup exact index in 0..3", (idx <= 4'd3), 1);
        tick();

        // Start and write while busy are ignored; exactly one done pulse
        a_load_tens();
        a_key = 8'd150; a_mode = 1'b0; a_start = 1'b1;
        tick();
        a_key = 8'd0; a_mode = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 4'd15; a_wr_data = 8'd0;
        tick();
        check("busy during search", a_busy, 1);
        tick();
        a_start = 1'b0; a_wr_en = 1'b0;
        done_cnt = 0;
        f = 1'b0; idx = '0;
        for (int i = 0; i < 15; i++) begin
            if (a_done) begin
                done_cnt++;
                f = a_found;
                idx = a_index;
            end
            tick();
        end
        check("busy-ignore done count", done_cnt, 1);
        check("busy-ignore found", f, 1);
        check("busy-ignore index", idx, 15);
        a_search(8'd150, 1'b0, f, idx, lat);
        check("dropped write found", f, 1);
        check("dropped write index", idx, 15);
        tick();

        // Start held high: next search begins in the idle cycle after FIN
        a_key = 8'd70; a_mode = 1'b0; a_start = 1'b1;
        tick();
        lat = 0;
        while (!a_done && lat < 40) begin tick(); lat++; end
        check("held start first done", a_done, 1);
        check("held start first index", a_index, 7);
        tick();
        check("held start idle busy", a_busy, 0);
        check("held start idle done", a_done, 0);
        tick();
        check("held start restarted busy", a_busy, 1);
        a_start = 1'b0;
        lat = 0;
        while (!a_done && lat < 40) begin tick(); lat++; end
        check("held start second done", a_done, 1);
        tick();

        // Asynchronous reset two cycles into a search
        a_key = 8'd150; a_mode = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        check("pre-reset busy", a_busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst busy",  a_busy,  0);
        check("async rst done",  a_done,  0);
        check("async rst found", a_found, 0);
        check("async rst index", a_index, 0);
        done_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (a_done) done_cnt++;
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_done) done_cnt++;
        end
        check("no done after reset", done_cnt, 0);
        a_search(8'd0, 1'b1, f, idx, lat);
        check("cleared lb0 found", f, 1);
        check("cleared lb0 index", idx, 0);
        tick();
        a_search(8'd1, 1'b1, f, idx, lat);
        check("cleared lb1 found", f, 0);
        tick();
        a_search(8'd150, 1'b0, f, idx, lat);
        check("cleared exact150 found", f, 0);
        tick();

        // Randomized sweep on the 64x12 instance against a linear-scan model
        for (int round = 0; round < 20; round++) begin
            int v;
            v = $urandom_range(0, 200);
            for (int i = 0; i < 64; i++) begin
                arr[i] = v;
                b_write(6'(i), 12'(v));
                v += $urandom_range(0, 60);
            end
            for (int s = 0; s < 10; s++) begin
                logic [11:0] k;
                logic        m;
                logic        bf;
                logic [5:0]  bidx;
                logic        exp_f;
                int          exp_idx;
                case ($urandom_range(0, 2))
                    0:       k = 12'(arr[$urandom_range(0, 63)]);
                    1:       k = 12'($urandom_range(0, 4095));
                    default: k = 12'(arr[$urandom_range(0, 63)] + 1);
                endcase
                m = 1'($urandom_range(0, 1));
                exp_f = 1'b0;
                exp_idx = 0;
                if (m) begin
                    for (int i = 63; i >= 0; i--) begin
                        if (arr[i] >= int'(k)) begin
                            exp_f = 1'b1;
                            exp_idx = i;
                        end
                    end
                end else begin
                    foreach (arr[i]) if (arr[i] == int'(k)) exp_f = 1'b1;
                end
                b_search(k, m, bf, bidx, lat);
                check($sformatf("r%0d.%0d found", round, s), bf, exp_f);
                if (m || !exp_f) begin
                    check($sformatf("r%0d.%0d index", round, s), bidx, exp_idx);
                end else begin
                    check($sformatf("r%0d.%0d matched value", round, s), arr[bidx], k);
                end
                check($sformatf("r%0d.%0d latency<=8", round, s), (lat <= 8), 1);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
